prim_clock_mux_ctrl: RTL and testbench
======================================

// Module: prim_clock_mux_ctrl
// PURPOSE
//  Sequencer for the 2:1 clock mux (prim_clock_mux2). Accepts clock-switch requests over a 4-phase req/ack handshake.
//  Gates the downstream clock enable off, flips the mux select, waits for settling, re-enables and acknowledges.
//  Runs in the always-on reference clock domain; drives prim_clock_mux2.sel_i and the downstream clock-gate enables.
// PARAMETERS
//  GateWait    4     cycles clk_en_o held low before sel_o changes (>=1)
//  SettleWait  8     cycles after sel_o changes before clk_en_o re-asserts (>=1)
//  ResetSel    1'b0  sel_o value while in and after reset
// PORTS
//  clk_i      in   1  always-on reference clock
//  rst_i      in   1  asynchronous, active-high reset
//  req_i      in   1  switch request, 4-phase; held high until ack_o
//  sel_req_i  in   1  target select; stable while req_i high
//  ack_o      out  1  request complete; high until req_i falls
//  sel_o      out  1  to prim_clock_mux2.sel_i
//  clk_en_o   out  1  downstream clock-gate enable
//  busy_o     out  1  high in any state other than IDLE
//  lock_i     in   1  [PRIM_CLOCK_MUX_CTRL_LOCK_EN only] lock request
//  err_o      out  1  [PRIM_CLOCK_MUX_CTRL_LOCK_EN only] request refused
// BEHAVIOUR
//  - All outputs registered. Reset (async assert) values:
//    sel_o=ResetSel, clk_en_o=1, ack_o=0, busy_o=0, err_o=0; state=IDLE; counter=0.
//  - Reset mid-operation aborts the sequence immediately to the reset values; no ack is issued.
//  - FSM states: IDLE, GATE_OFF, SWITCH, ACK.
//  - IDLE: on an edge sampling req_i=1 && ack_o=0:
//    - if sel_req_i==sel_o -> ACK; ack_o=1 after that edge; clk_en_o/sel_o untouched.
//    - else -> GATE_OFF; clk_en_o=0; counter loaded with GateWait-1.
//  - GATE_OFF: count down to 0 (GateWait cycles total) -> SWITCH; sel_o<=sel_req_i; counter loaded with SettleWait-1.
//  - SWITCH: count down to 0 (SettleWait cycles total) -> ACK; clk_en_o=1 and ack_o=1 on the same edge.
//  - ACK: hold ack_o=1 until req_i sampled 0 -> IDLE; ack_o=0 on that edge.
//    - A new request is accepted no earlier than the following edge.
//  - Latency: accepting edge to ack_o high = GateWait+SettleWait cycles for a real switch; 1 cycle for a no-op request.
//  - Invariant: sel_o never changes while clk_en_o=1.
//  - req_i dropped before ack_o: the sequence still completes; the FSM passes through ACK and returns to IDLE on the next edge.
//  - sel_req_i changing mid-sequence is ignored; the value latched at acceptance is used.
//  - Counter width: $clog2(max(GateWait,SettleWait)); minimum 1 bit. Counter never wraps; it is reloaded on each state entry.
// CONFIGURATION
//  PRIM_CLOCK_MUX_CTRL_LOCK_EN defined:
//  - Add lock_i and err_o.
//  - lock_i sampled high sets a sticky lock bit, cleared only by rst_i.
//  - A request accepted while locked goes straight to ACK with err_o=1; sel_o and clk_en_o are unchanged.
//  - err_o clears together with ack_o.
//  - Lock asserting mid-sequence does not abort the sequence in progress.
//  PRIM_CLOCK_MUX_CTRL_LOCK_EN undefined:
//  - No lock_i/err_o ports, no lock state; every request is honoured.
// STRUCTURE
//  - prim_clock_mux_ctrl_pkg: state enum (IDLE, GATE_OFF, SWITCH, ACK) and a function computing the counter width.
//  - Sub-module prim_clock_mux_ctrl_cnt: loadable down-counter with zero flag, parameterised width.
//  - Top level: FSM plus output registers.
// TESTING
//  1. Reset: assert rst_i mid-clock, ResetSel=0 -> sel_o=0, clk_en_o=1, ack_o=0, busy_o=0 without a clock edge.
//  2. Switch 0->1, G=4, S=8 -> clk_en_o low 12 cycles; sel_o flips 4 cycles after acceptance; ack_o high at cycle 12.
//  3. Request with sel_req_i==sel_o -> ack_o after 1 cycle; clk_en_o never drops.
//  4. Reset asserted in SWITCH -> outputs return to reset values; ack_o stays 0; next request completes normally.
//  5. req_i dropped in GATE_OFF -> sequence completes; ack_o pulses 1 cycle; back to IDLE.
//  6. LOCK_EN: pulse lock_i, then request 0->1 -> ack_o=err_o=1 after 1 cycle; sel_o stays 0; clk_en_o stays 1.

Source files
------------

// File: rtl/prim_clock_mux_ctrl_pkg.sv
// Shared types and helpers for the clock-mux switch sequencer.
package prim_clock_mux_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_OFF = 2'd1,
    SWITCH   = 2'd2,
    ACK      = 2'd3
  } state_e;

  // Wide enough to hold the larger of the two wait reloads; never narrower than 1 bit.
  function automatic int cnt_width(input int gate_wait, input int settle_wait);
    int max_wait;
    int width;
    max_wait = (gate_wait > settle_wait) ? gate_wait : settle_wait;
    width    = $clog2(max_wait);
    if (width < 1) begin
      width = 1;
    end else begin
      width = width;
    end
    return width;
  endfunction

endpackage

// File: rtl/prim_clock_mux_ctrl_cnt.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module prim_clock_mux_ctrl_cnt #(
  parameter int Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] count_r;

  // Count register: load has priority over decrement.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_r <= '0;
    end else if (load_i) begin
      count_r <= load_val_i;
    end else if (dec_i && (count_r != '0)) begin
      count_r <= count_r - Width'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero_o = (count_r == '0);

endmodule

// File: rtl/prim_clock_mux_ctrl.sv
// Req/ack sequencer for prim_clock_mux2: gate off, flip select, settle, re-enable, acknowledge.
// Optional feature macro: PRIM_CLOCK_MUX_CTRL_LOCK_EN adds lock_i / err_o request refusal.
module prim_clock_mux_ctrl
  import prim_clock_mux_ctrl_pkg::*;
#(
  parameter int   GateWait   = 4,
  parameter int   SettleWait = 8,
  parameter logic ResetSel   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic sel_req_i,
  output logic ack_o,
  output logic sel_o,
  output logic clk_en_o,
  output logic busy_o
`ifdef PRIM_CLOCK_MUX_CTRL_LOCK_EN
  ,
  input  logic lock_i,
  output logic err_o
`endif
);

  localparam int CntW = cnt_width(GateWait, SettleWait);
  localparam logic [CntW-1:0] GateLoad   = CntW'(GateWait - 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SettleWait - 1);

  state_e            state_r, state_nxt_s;
  logic              sel_r, sel_nxt_s;
  logic              clk_en_r, clk_en_nxt_s;
  logic              ack_r, ack_nxt_s;
  logic              busy_r;
  logic              tgt_r, tgt_nxt_s;
  logic              cnt_load_s, cnt_dec_s, cnt_zero_s;
  logic [CntW-1:0]   cnt_load_val_s;
  logic              accept_s;
  logic              locked_s;

  assign accept_s = (state_r == IDLE) && req_i && !ack_r;

`ifdef PRIM_CLOCK_MUX_CTRL_LOCK_EN
  logic lock_r;
  logic err_r;

  // Sticky lock; only reset clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_r <= 1'b0;
    end else begin
      lock_r <= lock_r | lock_i;
    end
  end

  // Refusal flag rises with the no-switch ack and falls with it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else if (accept_s && lock_r) begin
      err_r <= 1'b1;
    end else if ((state_r == ACK) && !req_i) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  assign locked_s = lock_r;
  assign err_o    = err_r;
`else
  assign locked_s = 1'b0;
`endif

  prim_clock_mux_ctrl_cnt #(
    .Width(CntW)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load_s),
    .load_val_i (cnt_load_val_s),
    .dec_i      (cnt_dec_s),
    .zero_o     (cnt_zero_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt_s    = state_r;
    sel_nxt_s      = sel_r;
    clk_en_nxt_s   = clk_en_r;
    ack_nxt_s      = ack_r;
    tgt_nxt_s      = tgt_r;
    cnt_load_s     = 1'b0;
    cnt_load_val_s = GateLoad;
    cnt_dec_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (locked_s || (sel_req_i == sel_r)) begin
            state_nxt_s = ACK;
            ack_nxt_s   = 1'b1;
          end else begin
            state_nxt_s    = GATE_OFF;
            clk_en_nxt_s   = 1'b0;
            tgt_nxt_s      = sel_req_i;
            cnt_load_s     = 1'b1;
            cnt_load_val_s = GateLoad;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GATE_OFF: begin
        if (cnt_zero_s) begin
          state_nxt_s    = SWITCH;
          sel_nxt_s      = tgt_r;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = SettleLoad;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      SWITCH: begin
        if (cnt_zero_s) begin
          state_nxt_s  = ACK;
          clk_en_nxt_s = 1'b1;
          ack_nxt_s    = 1'b1;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ACK: begin
        if (!req_i) begin
          state_nxt_s = IDLE;
          ack_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = ACK;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r  <= IDLE;
      sel_r    <= ResetSel;
      clk_en_r <= 1'b1;
      ack_r    <= 1'b0;
      busy_r   <= 1'b0;
      tgt_r    <= ResetSel;
    end else begin
      state_r  <= state_nxt_s;
      sel_r    <= sel_nxt_s;
      clk_en_r <= clk_en_nxt_s;
      ack_r    <= ack_nxt_s;
      busy_r   <= (state_nxt_s != IDLE);
      tgt_r    <= tgt_nxt_s;
    end
  end

  assign sel_o    = sel_r;
  assign clk_en_o = clk_en_r;
  assign ack_o    = ack_r;
  assign busy_o   = busy_r;

endmodule

// File: tb/tb_prim_clock_mux_ctrl.sv
// Directed bench for prim_clock_mux_ctrl with a timestamp-based reference model checked every cycle.
module tb_prim_clock_mux_ctrl;

  localparam int G = 4;
  localparam int S = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req = 1'b0;
  logic sel_req = 1'b0;
  logic ack, sel, en, busy;
`ifdef PRIM_CLOCK_MUX_CTRL_LOCK_EN
  logic lock = 1'b0;
  logic err;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  prim_clock_mux_ctrl #(
    .GateWait(G), .SettleWait(S), .ResetSel(1'b0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .sel_req_i(sel_req),
    .ack_o(ack), .sel_o(sel), .clk_en_o(en), .busy_o(busy)
`ifdef PRIM_CLOCK_MUX_CTRL_LOCK_EN
    , .lock_i(lock), .err_o(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a switch accepted at edge c moves sel at c+G and acks at c+G+S.
  logic m_sel, m_en, m_ack, m_busy, m_err, m_tgt, m_lock;
  int   cyc, flip_at, ack_at;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sel <= 1'b0; m_en <= 1'b1; m_ack <= 1'b0; m_busy <= 1'b0; m_err <= 1'b0;
      m_tgt <= 1'b0; m_lock <= 1'b0;
      cyc <= 0; flip_at <= -1; ack_at <= -1;
    end else begin
      cyc <= cyc + 1;
      if (!m_busy) begin
        if (req) begin
          m_busy <= 1'b1;
          if (m_lock || (sel_req == m_sel)) begin
            m_ack <= 1'b1;
            m_err <= m_lock;
          end else begin
            m_en    <= 1'b0;
            m_tgt   <= sel_req;
            flip_at <= cyc + G;
            ack_at  <= cyc + G + S;
          end
        end
      end else if (m_ack) begin
        if (!req) begin
          m_ack <= 1'b0; m_err <= 1'b0; m_busy <= 1'b0;
        end
      end else begin
        if (cyc == flip_at) m_sel <= m_tgt;
        if (cyc == ack_at) begin
          m_en  <= 1'b1;
          m_ack <= 1'b1;
        end
      end
`ifdef PRIM_CLOCK_MUX_CTRL_LOCK_EN
      m_lock <= m_lock | lock;
`else
      m_lock <= 1'b0;
`endif
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_sel", 32'(sel), 32'(m_sel));
      check("model_clk_en", 32'(en), 32'(m_en));
      check("model_ack", 32'(ack), 32'(m_ack));
      check("model_busy", 32'(busy), 32'(m_busy));
`ifdef PRIM_CLOCK_MUX_CTRL_LOCK_EN
      check("model_err", 32'(err), 32'(m_err));
`endif
    end
  end

  initial begin
    int en_low, flip_n, ack_n;
    logic a11, a12, a13, b13, s13;

    // 1. Reset mid-clock, before any edge.
    #3 rst = 1'b1;
    #1;
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_clk_en", 32'(en), 32'd1);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    chk_en = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 2. Real switch 0->1.
    req = 1'b1; sel_req = 1'b1;
    en_low = 0; flip_n = -1; ack_n = -1;
    for (int n = 0; n <= 12; n++) begin
      @(negedge clk);
      if (!en) en_low++;
      if (sel && flip_n < 0) flip_n = n;
      if (ack && ack_n < 0) ack_n = n;
    end
    check("sw_en_low_cycles", 32'(en_low), 32'd12);
    check("sw_sel_flip_cycle", 32'(flip_n), 32'd4);
    check("sw_ack_cycle", 32'(ack_n), 32'd12);
    req = 1'b0;
    @(negedge clk);
    check("sw_ack_drop", 32'(ack), 32'd0);
    check("sw_busy_drop", 32'(busy), 32'd0);

    // 3. No-op request: target equals current select.
    req = 1'b1; sel_req = 1'b1;
    @(negedge clk);
    check("noop_ack", 32'(ack), 32'd1);
    check("noop_clk_en", 32'(en), 32'd1);
    req = 1'b0;
    @(negedge clk);
    check("noop_ack_drop", 32'(ack), 32'd0);

    // 3b. Switch 1->0 with sel_req wiggled mid-sequence.
    req = 1'b1; sel_req = 1'b0;
    for (int n = 0; n <= 12; n++) begin
      @(negedge clk);
      if (n == 2) sel_req = 1'b1;
    end
    check("latched_sel", 32'(sel), 32'd0);
    check("latched_ack", 32'(ack), 32'd1);
    req = 1'b0;
    @(negedge clk);

    // 4. Reset while in SWITCH.
    req = 1'b1; sel_req = 1'b1;
    for (int n = 0; n <= 6; n++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_sel", 32'(sel), 32'd0);
    check("abort_clk_en", 32'(en), 32'd1);
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    req = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req = 1'b1; sel_req = 1'b1;
    for (int n = 0; n <= 12; n++) @(negedge clk);
    check("after_abort_sel", 32'(sel), 32'd1);
    check("after_abort_ack", 32'(ack), 32'd1);
    req = 1'b0;
    @(negedge clk);

    // 5. req dropped during GATE_OFF: still completes, ack pulses one cycle.
    req = 1'b1; sel_req = 1'b0;
    a11 = 1'b0; a12 = 1'b0; a13 = 1'b0; b13 = 1'b0; s13 = 1'b0;
    for (int n = 0; n <= 13; n++) begin
      @(negedge clk);
      if (n == 1) req = 1'b0;
      if (n == 11) a11 = ack;
      if (n == 12) a12 = ack;
      if (n == 13) begin a13 = ack; b13 = busy; s13 = sel; end
    end
    check("drop_ack_n11", 32'(a11), 32'd0);
    check("drop_ack_n12", 32'(a12), 32'd1);
    check("drop_ack_n13", 32'(a13), 32'd0);
    check("drop_busy_n13", 32'(b13), 32'd0);
    check("drop_sel", 32'(s13), 32'd0);

`ifdef PRIM_CLOCK_MUX_CTRL_LOCK_EN
    // 6. Locked: request is refused immediately.
    lock = 1'b1;
    @(negedge clk);
    lock = 1'b0;
    req = 1'b1; sel_req = 1'b1;
    @(negedge clk);
    check("lock_ack", 32'(ack), 32'd1);
    check("lock_err", 32'(err), 32'd1);
    check("lock_sel", 32'(sel), 32'd0);
    check("lock_clk_en", 32'(en), 32'd1);
    req = 1'b0;
    @(negedge clk);
    check("lock_ack_drop", 32'(ack), 32'd0);
    check("lock_err_drop", 32'(err), 32'd0);
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
